mac_array_sched: RTL and testbench

Scheduler and sequencer for the shared 6-lane fixed-point multiply-accumulate datapath used by the encoder/decoder dense layers. Two layer requesters share the array. The block arbitrates between them round-robin and samples the granted layer's input length. It then drives the datapath's element-select, bias-load, multiply and accumulate strobes so that one matrix-vector product (N inputs × 6 outputs, plus bias) completes per grant. It replaces per-layer free-running iteration counters with one start/done-handshaked controller.

---
 rtl/mac_array_sched.sv | 99 +++++++++
 tb/tb_mac_array_sched.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mac_array_sched.sv
// Round-robin scheduler/sequencer for the shared 6-lane MAC datapath.
// One grant runs LOAD (bias) -> ISSUE (n products) -> DRAIN -> DONE.
module mac_array_sched #(
  parameter int BITSIZE = 16,
  parameter int MAX_N   = 10,
  parameter int IDXW    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req,
  input  logic [IDXW-1:0] n_in0,
  input  logic [IDXW-1:0] n_in1,
  output logic [1:0]      gnt,
  output logic            busy,
  output logic [IDXW-1:0] x_sel,
  output logic [IDXW-1:0] w_row,
  output logic            mul_en,
  output logic            acc_load_bias,
  output logic            acc_en,
  output logic            out_valid,
  output logic            done,
  output logic            done_id,
  output logic            err
);

  if ((2 ** IDXW) <= MAX_N || BITSIZE < 1) begin : g_bad_cfg
    $error("mac_array_sched: IDXW too narrow for MAX_N or BITSIZE invalid");
  end

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;

  localparam logic [IDXW-1:0] NMAX = IDXW'(MAX_N);

  state_t          state, state_nx;
  logic [IDXW-1:0] k, n;
  logic [1:0]      gnt_q;
  logic            id, last, win, bad, k_last;

  // Tie goes to whoever was not served last; reset leaves last = 1 so 0 wins.
  assign win    = (req == 2'b11) ? ~last : req[1];
  assign bad    = (n == '0) || (n > NMAX);
  assign k_last = (k == n - IDXW'(1));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req) state_nx = LOAD;
      LOAD:    state_nx = bad ? DONE : ISSUE;
      ISSUE:   if (k_last) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      k     <= '0;
      n     <= '0;
      id    <= 1'b0;
      last  <= 1'b1;
      gnt_q <= 2'b00;
    end else begin
      case (state)
        IDLE: if (|req) begin
          gnt_q <= win ? 2'b10 : 2'b01;
          id    <= win;
          n     <= win ? n_in1 : n_in0;
        end
        LOAD:  k <= '0;
        ISSUE: if (!k_last) k <= k + IDXW'(1);
        DONE: begin
          last  <= id;
          gnt_q <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign gnt           = gnt_q;
  assign busy          = (state != IDLE);
  assign x_sel         = (state == ISSUE) ? k : '0;
  assign w_row         = x_sel;
  assign mul_en        = (state == ISSUE);
  assign acc_load_bias = (state == LOAD);
  // Accumulate lags multiply by one cycle; DRAIN picks up the final product.
  assign acc_en        = ((state == ISSUE) && (k != '0)) || (state == DRAIN);
  assign out_valid     = (state == DONE);
  assign done          = (state == DONE);
  assign done_id       = (state == DONE) && id;
  assign err           = (state == DONE) && bad;

endmodule

// File: tb/tb_mac_array_sched.sv
// Directed bench for mac_array_sched with a small 6-lane MAC datapath model
// driven by the block's strobes to confirm bias + sum(x*w) at out_valid.
module tb_mac_array_sched;
  localparam int MAX_N = 10;
  localparam int IDXW  = 4;
  localparam int L     = 6;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      req = 2'b00;
  logic [IDXW-1:0] n_in0 = '0, n_in1 = '0;
  logic [1:0]      gnt;
  logic            busy, mul_en, acc_load_bias, acc_en, out_valid, done, done_id, err;
  logic [IDXW-1:0] x_sel, w_row;

  int n_cmp = 0;
  int n_err = 0;
  int prod [L];
  int acc  [L];

  mac_array_sched #(.BITSIZE(16), .MAX_N(MAX_N), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .req(req), .n_in0(n_in0), .n_in1(n_in1),
    .gnt(gnt), .busy(busy), .x_sel(x_sel), .w_row(w_row), .mul_en(mul_en),
    .acc_load_bias(acc_load_bias), .acc_en(acc_en), .out_valid(out_valid),
    .done(done), .done_id(done_id), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int xv(int i);          return i + 1;          endfunction
  function automatic int wv(int i, int l);   return 2 * i + l + 1;  endfunction
  function automatic int bias(int l);        return 100 * l + 7;    endfunction

  // Datapath model: product register and accumulator per lane.
  always @(posedge clk) begin
    for (int l = 0; l < L; l++) begin
      if (mul_en) prod[l] <= xv(int'(x_sel)) * wv(int'(w_row), l);
      if (acc_load_bias) acc[l] <= bias(l);
      else if (acc_en)   acc[l] <= acc[l] + prod[l];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] obs();
    return {gnt, busy, x_sel, w_row, mul_en, acc_load_bias, acc_en, out_valid, done, done_id, err};
  endfunction

  // Expected outputs c cycles after LOAD, derived from the run timeline.
  function automatic logic [17:0] exp_vec(int c, int n, bit id, bit bad);
    int lb = bad ? 1 : n + 2;
    logic [1:0] g = 2'b00;
    logic [3:0] x = 4'd0;
    logic by = 1'b0, m = 1'b0, ae = 1'b0, dn;
    if (c <= lb) begin
      g  = id ? 2'b10 : 2'b01;
      by = 1'b1;
    end
    if (!bad && c >= 1 && c <= n) begin
      x  = 4'(c - 1);
      m  = 1'b1;
      ae = (c >= 2);
    end
    if (!bad && c == n + 1) ae = 1'b1;
    dn = (c == lb);
    return {g, by, x, x, m, (c == 0), ae, dn, dn, dn & id, dn & bad};
  endfunction

  // Call with req already driven; first negedge observed is the LOAD cycle.
  task automatic watch_run(input string tag, input int n, input bit id, input bit bad,
                           input logic [1:0] drop);
    int last = bad ? 2 : n + 3;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d", tag, c), 32'(obs()), 32'(exp_vec(c, n, id, bad)));
      if (!bad && c == n + 2) begin
        for (int l = 0; l < L; l++) begin
          int s = bias(l);
          for (int i = 0; i < n; i++) s += xv(i) * wv(i, l);
          chk($sformatf("%s acc%0d", tag, l), 32'(acc[l]), 32'(s));
        end
      end
      if (c == last - 1) req = req & ~drop;
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(obs()), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_outs", 32'(obs()), 32'd0);

    // Single run at MAX_N.
    n_in0 = 4'd10; req = 2'b01;
    watch_run("single", 10, 1'b0, 1'b0, 2'b01);

    // Simultaneous requests straight after reset: 0 wins, then 1.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_in0 = 4'd3; n_in1 = 4'd5; req = 2'b11;
    watch_run("sim0", 3, 1'b0, 1'b0, 2'b01);
    watch_run("sim1", 5, 1'b1, 1'b0, 2'b10);

    // Fairness: both held across four runs.
    n_in0 = 4'd2; n_in1 = 4'd4; req = 2'b11;
    watch_run("fair0", 2, 1'b0, 1'b0, 2'b00);
    watch_run("fair1", 4, 1'b1, 1'b0, 2'b00);
    watch_run("fair2", 2, 1'b0, 1'b0, 2'b00);
    watch_run("fair3", 4, 1'b1, 1'b0, 2'b11);

    // Shortest valid run.
    n_in0 = 4'd1; req = 2'b01;
    watch_run("n1", 1, 1'b0, 1'b0, 2'b01);

    // Invalid lengths.
    n_in1 = 4'd0; req = 2'b10;
    watch_run("bad0", 0, 1'b1, 1'b1, 2'b10);
    n_in1 = 4'd11; req = 2'b10;
    watch_run("bad11", 11, 1'b1, 1'b1, 2'b10);

    // Reset during ISSUE at k = 4, then a fresh run with req still high.
    n_in0 = 4'd10; req = 2'b01;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("pre_rst c%0d", c), 32'(obs()), 32'(exp_vec(c, 10, 1'b0, 1'b0)));
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid", 32'(obs()), 32'd0);
    reset = 1'b1;
    watch_run("after_rst", 10, 1'b0, 1'b0, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
